// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - two-requester arbiter sharing one ALU datapath (option: ALU_ARB_RR_EN selects round-robin)
module alu_req_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_fun,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_fun,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_fun,
    output logic             arith_en,
    output logic             logic_en,
    output logic             cmp_en,
    output logic             shift_en,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       fun_q;
    logic             id_q;
    logic             gnt;
    logic             take;
    logic             issue;

`ifdef ALU_ARB_RR_EN
    logic             last_q;
`endif

    // Grant selection: a lone requester wins; contention resolved by pointer or fixed priority
    always_comb begin
        gnt = 1'b0;
        if (req1_valid && !req0_valid) begin
            gnt = 1'b1;
        end else if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
            gnt = ~last_q;
`else
            gnt = 1'b0;
`endif
        end
    end

    // Readys only in IDLE; gated by reset so every output is 0 while reset is held
    always_comb begin
        req0_ready = rst && (state == IDLE) && req0_valid && !gnt;
        req1_ready = rst && (state == IDLE) && req1_valid && gnt;
        take       = req0_ready || req1_ready;
    end

    // Next-state logic for the issue/wait/respond sequence
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (take) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register; asynchronous reset drops any in-flight operation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Capture the granted request and, one cycle after the enable, the ALU result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            fun_q    <= '0;
            id_q     <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (take) begin
                a_q   <= gnt ? req1_a : req0_a;
                b_q   <= gnt ? req1_b : req0_b;
                fun_q <= gnt ? req1_fun : req0_fun;
                id_q  <= gnt;
            end
            if (state == WAIT) begin
                rsp_data <= alu_out;
                rsp_err  <= ~alu_flag;
            end
        end
    end

`ifdef ALU_ARB_RR_EN
    // Round-robin pointer remembers the last granted requester; moves only on a handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else if (take) begin
            last_q <= gnt;
        end
    end
`endif

    // Datapath drive and one-hot unit enable, decoded from the registered function
    always_comb begin
        issue     = (state == ISSUE);
        alu_a     = a_q;
        alu_b     = b_q;
        alu_fun   = fun_q[1:0];
        arith_en  = issue && (fun_q[3:2] == 2'b00);
        logic_en  = issue && (fun_q[3:2] == 2'b01);
        cmp_en    = issue && (fun_q[3:2] == 2'b10);
        shift_en  = issue && (fun_q[3:2] == 2'b11);
        rsp_valid = (state == RESP);
        rsp_id    = id_q;
    end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Shares one ALU datapath (arithmetic, logic, compare and shift units, each with a one-cycle registered output and a completion flag) between two independent requesters. Each requester hands over operands and a 4-bit function code with a valid/ready handshake. The arbiter grants one request at a time, decodes the function into a single unit enable, captures the result, and returns it tagged with the requester ID. It sits between the instruction-issue logic and the ALU unit instances.

## Interface
- WIDTH, 16, operand/result width
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- req0_valid, req1_valid  in  1  request present
- req0_ready, req1_ready  out  1  request accepted when valid&ready
- req0_a, req0_b, req1_a, req1_b  in  WIDTH  operands
- req0_fun, req1_fun  in  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift), [1:0] unit function
- alu_a, alu_b  out  WIDTH  operands to all units
- alu_fun  out  2  function to all units
- arith_en, logic_en, cmp_en, shift_en  out  1  unit enables, at most one high
- alu_out  in  WIDTH  muxed result of the enabled unit
- alu_flag  in  1  OR of unit flags; high the cycle after an enable
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when valid&ready
- rsp_id  out  1  requester that issued the operation
- rsp_data  out  WIDTH  captured result
- rsp_err  out  1  alu_flag was absent when expected

## Operation
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Compute the grant from the valid requests.
  - Assert the granted requester's ready (combinational from valid and the grant). The other requester's ready stays 0.
  - On handshake, register a, b, fun and id, then go to ISSUE. With no valid request, stay in IDLE.
- ISSUE:
  - Drive the registered operands onto alu_a, alu_b and alu_fun.
  - Assert exactly one enable, decoded from fun[3:2], for exactly one cycle.
  - Go to WAIT.
- WAIT:
  - Hold alu_a, alu_b and alu_fun; all enables are 0.
  - Capture alu_out into rsp_data.
  - Set rsp_err = ~alu_flag. The result is captured even when the flag is missing.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are stable.
  - On rsp_ready, go to IDLE.
  - While rsp_ready=0, hold indefinitely (backpressure). Both req readys stay 0.
- Grant rule: a lone valid requester always wins. The contention rule is set in Configuration.
- A requester must keep valid and its payload stable until ready. The arbiter never revokes a grant within IDLE.
- Reset values, all 0: every output, the state (IDLE) and the captured registers. The round-robin pointer resets to "last granted = 1", so requester 0 wins the first contention.
- Reset mid-operation: the in-flight operation is dropped and no response is produced. Any unit enable deasserts immediately (asynchronously).

## Timing
- Request handshake in cycle N:
  - N+1: enable high.
  - N+2: alu_flag expected; result captured at the end of N+2.
  - N+3: rsp_valid high.
- Latency from handshake to rsp_valid is 3 cycles.
- Best throughput is one operation per 4 cycles (rsp_ready tied high). The next request handshake can occur in the cycle after the response handshake.
- The response handshake and the next grant are never in the same cycle.
- req readys are 0 in ISSUE, WAIT and RESP.

## Configuration
- ALU_ARB_RR_EN defined: round-robin on contention. When both requesters are valid in IDLE, grant the one not granted last. The pointer updates only on a request handshake.
- ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins on contention. No pointer register exists.

## Test plan
- Single request: req0 with a=0x00F0, b=0x0FF0, fun=4'b0100 (logic AND), alu_out model returns 0x00F0 with flag -> logic_en high only in cycle N+1; rsp_valid at N+3 with id=0, data=0x00F0, err=0.
- Contention, RR build: both requesters continuously valid -> grants go 0,1,0,1 across four operations. Fixed-priority build: all four grants go to 0.
- Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid, id and data stay constant, both req readys stay 0; response completes on the first rsp_ready=1, and the next grant comes in the following cycle.
- Missing flag: alu_flag forced 0 in WAIT with alu_out=0x1234 -> response has data=0x1234, err=1.
- Decode: fun[3:2] = 00, 01, 10, 11 in turn -> exactly arith_en, logic_en, cmp_en, shift_en respectively pulse for one cycle; alu_fun equals fun[1:0].
- Reset in WAIT: rst low for 1 cycle -> all outputs 0 and no response. After release, a new req1 request is served normally with id=1.
